// File: rtl/fetch_unit.sv
//==============================================================================
// Module   : fetch_unit
// Brief    : Instruction-fetch stage. Owns the architectural PC, issues one
//            outstanding word fetch over a req/gnt/rvalid handshake, presents
//            the fetched word with PC and PC+4 under valid/ready, and squashes
//            in-flight fetches on branch/jump redirects.
// Options  : FETCH_PERF_CNT_EN - adds perf_fetched / perf_squashed counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_squashed,
`endif
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc4,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              if_valid_q, if_valid_d;
    logic [31:0]       if_instr_q, if_instr_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [ADDR_W-1:0] if_pc4_q, if_pc4_d;

    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              load_instr;
    logic              redirect_lsb_unused;

    // Redirect targets are word aligned; the two low bits are dropped.
    assign redirect_pc         = {redirect_addr[ADDR_W-1:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_addr[1:0];
    assign pc_plus4            = pc_q + ADDR_W'(4);

    // A response is captured only in WAIT and only if no redirect kills it.
    assign load_instr = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect takes priority over every other event.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (imem_gnt) begin
                    state_d = redirect_valid ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (redirect_valid || if_ready) begin
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Memory-side outputs: request only in REQ, address is always the PC.
    always_comb begin
        imem_req  = (state_q == S_REQ);
        imem_addr = pc_q;
    end

    // Datapath next values: PC update and downstream output capture.
    always_comb begin
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            if_valid_d = 1'b0;
        end else if (load_instr) begin
            pc_d       = pc_plus4;
            if_valid_d = 1'b1;
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            if_pc4_d   = pc_plus4;
        end else if ((state_q == S_VALID) && if_ready) begin
            if_valid_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_ADDR;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_pc4_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;
    assign if_pc4   = if_pc4_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_squashed_q;
    logic        fetched_evt;
    logic        squashed_evt;

    // A transfer killed by a same-cycle redirect is not counted as fetched.
    assign fetched_evt  = (state_q == S_VALID) && if_ready && !redirect_valid;
    assign squashed_evt = imem_rvalid &&
                          ((state_q == S_DROP) || ((state_q == S_WAIT) && redirect_valid));

    // Free-running wrap-around event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            if (fetched_evt) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (squashed_evt) begin
                perf_squashed_q <= perf_squashed_q + 32'd1;
            end
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//==============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_squashed;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_squashed  (perf_squashed),
`endif
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in REQ; leaves the DUT in VALID holding the fetched word.
    task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] data);
        check("req_req",   {31'd0, imem_req}, 32'd1);
        check("req_addr",  imem_addr, exp_pc);
        imem_gnt = 1'b1;
        tick();
        check("wait_req",  {31'd0, imem_req}, 32'd0);
        check("wait_vld",  {31'd0, if_valid}, 32'd0);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        check("vld_vld",   {31'd0, if_valid}, 32'd1);
        check("vld_instr", if_instr, data);
        check("vld_pc",    if_pc, exp_pc);
        check("vld_pc4",   if_pc4, exp_pc + 32'd4);
        check("vld_req",   {31'd0, imem_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'd0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 32'd0;
        tick();
        tick();
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_pc",    if_pc, 32'd0);
        check("rst_pc4",   if_pc4, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_req",  {31'd0, imem_req}, 32'd1);
        check("post_rst_addr", imem_addr, 32'd0);

        // Zero-wait memory, ready always high: one instruction per 3 cycles.
        if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_fetch(32'(i * 4), 32'(i * 4));
            tick();
            check("t1_vld_drop", {31'd0, if_valid}, 32'd0);
        end
`ifdef FETCH_PERF_CNT_EN
        check("t1_perf_fetched", perf_fetched, 32'd3);
`endif

        // Backpressure: outputs held, no new request while stalled.
        if_ready = 1'b0;
        do_fetch(32'h0000_000C, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_vld",   {31'd0, if_valid}, 32'd1);
            check("t2_hold_instr", if_instr, 32'hDEAD_BEEF);
            check("t2_hold_pc",    if_pc, 32'h0000_000C);
            check("t2_hold_req",   {31'd0, imem_req}, 32'd0);
        end
        if_ready = 1'b1;
        tick();
        check("t2_next_req",  {31'd0, imem_req}, 32'd1);
        check("t2_next_addr", imem_addr, 32'h0000_0010);
        check("t2_vld_drop",  {31'd0, if_valid}, 32'd0);

        // Redirect while waiting; the late response is dropped.
        imem_gnt = 1'b1;
        tick();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        check("t3_drop_req", {31'd0, imem_req}, 32'd0);
        check("t3_drop_vld", {31'd0, if_valid}, 32'd0);
        tick();
        check("t3_drop_hold", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        check("t3_no_vld", {31'd0, if_valid}, 32'd0);
        check("t3_req",    {31'd0, imem_req}, 32'd1);
        check("t3_addr",   imem_addr, 32'h0000_0100);
`ifdef FETCH_PERF_CNT_EN
        check("t3_perf_squashed", perf_squashed, 32'd1);
`endif
        do_fetch(32'h0000_0100, 32'h1234_5678);
        tick();

        // Redirect in VALID with ready high: instruction killed, not counted.
        do_fetch(32'h0000_0104, 32'hCAFE_0104);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        check("t4_vld",  {31'd0, if_valid}, 32'd0);
        check("t4_req",  {31'd0, imem_req}, 32'd1);
        check("t4_addr", imem_addr, 32'h0000_0200);
`ifdef FETCH_PERF_CNT_EN
        check("t4_perf_fetched", perf_fetched, 32'd5);
`endif

        // Redirect coincident with rvalid in WAIT: straight back to REQ.
        imem_gnt = 1'b1;
        tick();
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'h5555_AAAA;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0300;
        tick();
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        check("t5_vld",  {31'd0, if_valid}, 32'd0);
        check("t5_req",  {31'd0, imem_req}, 32'd1);
        check("t5_addr", imem_addr, 32'h0000_0300);

        // Redirect with grant in REQ, then a newer redirect while in DROP.
        imem_gnt       = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0404;
        tick();
        imem_gnt      = 1'b0;
        redirect_addr = 32'h0000_0508;
        check("t6_drop_req", {31'd0, imem_req}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        check("t6_req",  {31'd0, imem_req}, 32'd1);
        check("t6_addr", imem_addr, 32'h0000_0508);
`ifdef FETCH_PERF_CNT_EN
        check("t6_perf_squashed", perf_squashed, 32'd3);
`endif

        // Redirect in REQ without grant: new address on the next cycle.
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0600;
        tick();
        check("t7_req",  {31'd0, imem_req}, 32'd1);
        check("t7_addr", imem_addr, 32'h0000_0600);

        // PC wrap at the top of the address space (unaligned target forced down).
        redirect_addr = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        check("t8_addr", imem_addr, 32'hFFFF_FFFC);
        do_fetch(32'hFFFF_FFFC, 32'h0BAD_F00D);
        check("t8_pc4", if_pc4, 32'h0000_0000);
        tick();
        check("t8_next_addr", imem_addr, 32'h0000_0000);

        // Reset asserted while in DROP.
        imem_gnt = 1'b1;
        tick();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        check("t9_in_drop", {31'd0, imem_req}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t9_req",   {31'd0, imem_req}, 32'd1);
        check("t9_addr",  imem_addr, 32'h0000_0000);
        check("t9_vld",   {31'd0, if_valid}, 32'd0);
        check("t9_pc",    if_pc, 32'd0);
        check("t9_pc4",   if_pc4, 32'd0);
        check("t9_instr", if_instr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("t9_perf_fetched",  perf_fetched, 32'd0);
        check("t9_perf_squashed", perf_squashed, 32'd0);
`endif
        tick();
        check("t9_hold_req",  {31'd0, imem_req}, 32'd1);
        check("t9_hold_addr", imem_addr, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
